// File: rtl/bp_resolver_if.sv
// Handshake bundle between the execute stage (master) and the branch resolver (slave).
// Carries the prediction push port, the resolve port and the predictor update/statistics outputs.
interface bp_resolver_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int PEND_W = $clog2(DEPTH) + 1;

    logic              pred_valid;
    logic [3:0]        pred_code;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic              res_ready;
    logic              jump;
    logic              upd_en;
    logic              mispredict;
    logic              code_err;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output pred_valid, pred_code, res_valid, res_taken,
        input  pred_ready, res_ready, jump, upd_en, mispredict,
               code_err, pending, hit_cnt, miss_cnt
    );

    modport slave (
        input  pred_valid, pred_code, res_valid, res_taken,
        output pred_ready, res_ready, jump, upd_en, mispredict,
               code_err, pending, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/bp_resolver.sv
// Execute-stage companion of the 2-bit branch predictor: queues predicted directions,
// resolves them in FIFO order, strobes the predictor update and keeps hit/miss statistics.
module bp_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    bp_resolver_if.slave bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int PEND_W = AW + 1;

    logic              r_q [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [PEND_W-1:0] r_pending;
    logic              r_jump;
    logic              r_upd_en;
    logic              r_mispredict;
    logic              r_code_err;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic w_full;
    logic w_empty;
    logic w_push_hs;
    logic w_legal;
    logic w_pred_t;
    logic w_pop;
    logic w_head;
    logic w_miss;
    logic w_push_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_full    = (r_pending == PEND_W'(DEPTH));
    assign w_empty   = (r_pending == '0);
    assign w_push_hs = bus.pred_valid && bus.pred_ready;
    assign w_legal   = (bus.pred_code == 4'd0) || (bus.pred_code == 4'd3) ||
                       (bus.pred_code == 4'd9) || (bus.pred_code == 4'd6);
    assign w_pred_t  = (bus.pred_code == 4'd9) || (bus.pred_code == 4'd6);
    assign w_pop     = bus.res_valid && !w_empty;
    assign w_head    = r_q[r_rd];
    assign w_miss    = w_pop && (w_head != bus.res_taken);
    // A push that lands in a mispredict cycle is on the wrong path and never enters the queue.
    assign w_push_q  = w_push_hs && w_legal && !w_miss;

    // Storage carries no reset; validity is tracked entirely by the pointers and r_pending.
    always_ff @(posedge clk) begin
        if (w_push_q) begin
            r_q[r_wr] <= w_pred_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_pending    <= '0;
            r_jump       <= 1'b0;
            r_upd_en     <= 1'b0;
            r_mispredict <= 1'b0;
            r_code_err   <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_upd_en     <= w_pop;
            r_mispredict <= w_miss;
            if (w_pop) begin
                r_jump <= bus.res_taken;
            end
            if (w_push_hs && !w_legal) begin
                r_code_err <= 1'b1;
            end
            if (w_miss) begin
                r_wr       <= '0;
                r_rd       <= '0;
                r_pending  <= '0;
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end else begin
                if (w_push_q) begin
                    r_wr <= r_wr + AW'(1);
                end
                if (w_pop) begin
                    r_rd      <= r_rd + AW'(1);
                    r_hit_cnt <= sat_inc(r_hit_cnt);
                end
                r_pending <= r_pending + PEND_W'(w_push_q) - PEND_W'(w_pop);
            end
        end
    end

    // Ready is masked by reset so every output reads 0 while rst_n is low.
    assign bus.pred_ready = rst_n && !w_full;
    assign bus.res_ready  = !w_empty;
    assign bus.jump       = r_jump;
    assign bus.upd_en     = r_upd_en;
    assign bus.mispredict = r_mispredict;
    assign bus.code_err   = r_code_err;
    assign bus.pending    = r_pending;
    assign bus.hit_cnt    = r_hit_cnt;
    assign bus.miss_cnt   = r_miss_cnt;
endmodule

// File: tb/tb_bp_resolver.sv
// Directed-vector bench for bp_resolver (DEPTH=4, CNT_W=8) with hand-computed expectations.
module tb_bp_resolver;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bp_resolver_if #(.DEPTH(4), .CNT_W(8)) bus ();

    bp_resolver #(.DEPTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] code);
        bus.pred_valid = 1'b1;
        bus.pred_code  = code;
        tick();
        bus.pred_valid = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_pending"}, 32'(bus.pending), 0);
        chk({tag, "_upd_en"},  32'(bus.upd_en), 0);
        chk({tag, "_mispred"}, 32'(bus.mispredict), 0);
        chk({tag, "_jump"},    32'(bus.jump), 0);
        chk({tag, "_codeerr"}, 32'(bus.code_err), 0);
        chk({tag, "_hit"},     32'(bus.hit_cnt), 0);
        chk({tag, "_miss"},    32'(bus.miss_cnt), 0);
        chk({tag, "_pready"},  32'(bus.pred_ready), 0);
        chk({tag, "_rready"},  32'(bus.res_ready), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.pred_valid = 1'b0;
        bus.pred_code  = 4'd0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        repeat (2) tick();
        all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("pready_after_rst", 32'(bus.pred_ready), 1);

        // 1: three correct predictions in FIFO order
        push(4'd6);
        push(4'd0);
        push(4'd9);
        chk("t1_pending3", 32'(bus.pending), 3);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        tick();
        chk("t1_upd_a", 32'(bus.upd_en), 1);
        chk("t1_jump_a", 32'(bus.jump), 1);
        chk("t1_mis_a", 32'(bus.mispredict), 0);
        chk("t1_pending2", 32'(bus.pending), 2);
        bus.res_taken = 1'b0;
        tick();
        chk("t1_upd_b", 32'(bus.upd_en), 1);
        chk("t1_jump_b", 32'(bus.jump), 0);
        chk("t1_mis_b", 32'(bus.mispredict), 0);
        bus.res_taken = 1'b1;
        tick();
        chk("t1_jump_c", 32'(bus.jump), 1);
        chk("t1_mis_c", 32'(bus.mispredict), 0);
        bus.res_valid = 1'b0;
        tick();
        chk("t1_upd_off", 32'(bus.upd_en), 0);
        chk("t1_jump_held", 32'(bus.jump), 1);
        chk("t1_hit3", 32'(bus.hit_cnt), 3);
        chk("t1_miss0", 32'(bus.miss_cnt), 0);
        chk("t1_empty", 32'(bus.pending), 0);

        // 2: mispredict flushes both entries
        push(4'd3);
        push(4'd3);
        chk("t2_pending2", 32'(bus.pending), 2);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        chk("t2_mis", 32'(bus.mispredict), 1);
        chk("t2_upd", 32'(bus.upd_en), 1);
        chk("t2_jump", 32'(bus.jump), 1);
        chk("t2_pending0", 32'(bus.pending), 0);
        chk("t2_miss1", 32'(bus.miss_cnt), 1);
        chk("t2_rready0", 32'(bus.res_ready), 0);
        tick();
        chk("t2_mis_strobe", 32'(bus.mispredict), 0);
        chk("t2_upd_strobe", 32'(bus.upd_en), 0);

        // 3: offset pointers by one, fill to full across the wrap, hold off a push
        push(4'd0);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        tick();
        bus.res_valid = 1'b0;
        push(4'd6);
        push(4'd0);
        push(4'd0);
        push(4'd6);
        chk("t3_full", 32'(bus.pending), 4);
        chk("t3_pready0", 32'(bus.pred_ready), 0);
        bus.pred_valid = 1'b1;
        bus.pred_code  = 4'd9;
        tick();
        chk("t3_held_pending", 32'(bus.pending), 4);
        chk("t3_held_pready", 32'(bus.pred_ready), 0);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        chk("t3_pop_pending", 32'(bus.pending), 3);
        chk("t3_pop_pready", 32'(bus.pred_ready), 1);
        chk("t3_pop_mis", 32'(bus.mispredict), 0);
        tick();
        bus.pred_valid = 1'b0;
        chk("t3_refill", 32'(bus.pending), 4);
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        tick();
        chk("t3_ord1_mis", 32'(bus.mispredict), 0);
        tick();
        chk("t3_ord2_mis", 32'(bus.mispredict), 0);
        bus.res_taken = 1'b1;
        tick();
        chk("t3_ord3_mis", 32'(bus.mispredict), 0);
        tick();
        chk("t3_ord4_mis", 32'(bus.mispredict), 0);
        chk("t3_ord4_upd", 32'(bus.upd_en), 1);
        bus.res_valid = 1'b0;
        chk("t3_hit9", 32'(bus.hit_cnt), 9);
        chk("t3_empty", 32'(bus.pending), 0);

        // simultaneous push and correct pop keeps count and order
        push(4'd6);
        bus.pred_valid = 1'b1;
        bus.pred_code  = 4'd0;
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b1;
        tick();
        bus.pred_valid = 1'b0;
        chk("pp_pending1", 32'(bus.pending), 1);
        bus.res_taken = 1'b0;
        tick();
        bus.res_valid = 1'b0;
        chk("pp_order_mis", 32'(bus.mispredict), 0);
        chk("pp_hit11", 32'(bus.hit_cnt), 11);

        // 4: illegal code is accepted, not queued, and sticks
        push(4'h5);
        chk("t4_codeerr", 32'(bus.code_err), 1);
        chk("t4_pending", 32'(bus.pending), 0);
        tick();
        chk("t4_sticky", 32'(bus.code_err), 1);

        // 5: pushes coincident with a mispredict are discarded
        push(4'd3);
        bus.pred_valid = 1'b1;
        bus.pred_code  = 4'd9;
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b1;
        tick();
        chk("t5a_mis", 32'(bus.mispredict), 1);
        chk("t5a_pending", 32'(bus.pending), 0);
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        push(4'd6);
        bus.pred_valid = 1'b1;
        bus.pred_code  = 4'd0;
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b0;
        tick();
        chk("t5b_mis", 32'(bus.mispredict), 1);
        chk("t5b_pending", 32'(bus.pending), 0);
        bus.pred_valid = 1'b0;
        chk("t5_rready0", 32'(bus.res_ready), 0);
        tick();
        chk("t5_ignored_upd", 32'(bus.upd_en), 0);
        chk("t5_ignored_pend", 32'(bus.pending), 0);
        chk("t5_miss3", 32'(bus.miss_cnt), 3);
        bus.res_valid = 1'b0;

        // asynchronous reset clears sticky error without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        #1;

        // 6: hit counter saturation, then reset mid-stream
        push(4'd6);
        bus.pred_valid = 1'b1;
        bus.pred_code  = 4'd6;
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b1;
        repeat (254) tick();
        chk("t6_hit254", 32'(bus.hit_cnt), 254);
        repeat (5) tick();
        chk("t6_hit_sat", 32'(bus.hit_cnt), 255);
        chk("t6_miss0", 32'(bus.miss_cnt), 0);
        chk("t6_pending1", 32'(bus.pending), 1);
        chk("t6_upd", 32'(bus.upd_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("t6_async");
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
